isr_nesting_stack: RTL and testbench

In-service tracking stage directly downstream of the interrupt priority encoder. It consumes the encoder's `int_valid`, `irq_id` and the CPU's `cpu_ack`, and records each acknowledged interrupt on a nesting stack. It pops entries on end-of-interrupt (EOI). It drives `current_isr_priority` back into the encoder, so only strictly higher-priority requests (lower ID) can preempt.

---
 rtl/isr_nesting_stack.sv | 152 +++++++++++++++
 tb/tb_isr_nesting_stack.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/isr_nesting_stack.sv
// Interrupt in-service nesting stack: tracks acknowledged IRQs, pops on EOI and feeds the
// current in-service priority back to the encoder. Error reporting is built only when ISR_NEST_ERR_FLAGS_EN is defined.
module isr_nesting_stack #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned ID_W  = 3,
  localparam int unsigned DW    = $clog2(DEPTH + 1),
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned NI    = 1 << ID_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            int_valid,
  input  logic [ID_W-1:0] irq_id,
  input  logic            cpu_ack,
  input  logic            eoi,
  input  logic            err_clr,
  output logic [ID_W-1:0] current_isr_priority,
  output logic [NI-1:0]   isr_active,
  output logic [DW-1:0]   nest_depth,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            overflow_err,
  output logic            underflow_err,
  output logic            order_err
);

  logic [ID_W-1:0] stack_q [DEPTH];
  logic [DW-1:0]   depth_q,  depth_d;
  logic [ID_W-1:0] top_q,    top_d;
  logic [NI-1:0]   active_q, active_d;
  logic            empty_q,  empty_d;
  logic            full_q,   full_d;

  logic            push_req;
  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [DW-1:0]   base_depth;
  logic [ID_W-1:0] base_top;
  logic [NI-1:0]   base_active;
  logic            ovf_evt, udf_evt, ord_evt;

  // NOTE: every signal assigned here gets a default first, so no path leaves a latch behind.
  always_comb begin
    push_req    = cpu_ack & int_valid;
    ovf_evt     = 1'b0;
    udf_evt     = 1'b0;
    ord_evt     = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = '0;
    base_depth  = depth_q;
    base_top    = top_q;
    base_active = active_q;

    // The pop is retired first; a simultaneous push is judged against what it reveals.
    if (eoi) begin
      if (depth_q == '0) begin
        udf_evt = 1'b1;
      end else begin
        base_depth            = depth_q - DW'(1);
        base_active[top_q]    = 1'b0;
        base_top              = (depth_q > DW'(1)) ? stack_q[AW'(depth_q - DW'(2))] : '1;
      end
    end

    depth_d  = base_depth;
    top_d    = base_top;
    active_d = base_active;

    if (push_req) begin
      if ((base_depth != '0) && (irq_id >= base_top)) begin
        ord_evt = 1'b1;
      end else if (base_depth == DW'(DEPTH)) begin
        ovf_evt = 1'b1;
      end else begin
        wr_en            = 1'b1;
        wr_idx           = AW'(base_depth);
        depth_d          = base_depth + DW'(1);
        top_d            = irq_id;
        active_d[irq_id] = 1'b1;
      end
    end

    empty_d = (depth_d == '0);
    full_d  = (depth_d == DW'(DEPTH));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      depth_q  <= '0;
      top_q    <= '1;
      active_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      depth_q  <= depth_d;
      top_q    <= top_d;
      active_q <= active_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // NOTE: the stack RAM is deliberately not reset; slots at or above depth are never read.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      stack_q[wr_idx] <= irq_id;
    end
  end

  assign current_isr_priority = top_q;
  assign isr_active           = active_q;
  assign nest_depth           = depth_q;
  assign stack_empty          = empty_q;
  assign stack_full           = full_q;

`ifdef ISR_NEST_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic ord_q, ord_d;

  // A new event in the same cycle as err_clr keeps its flag set.
  always_comb begin
    ovf_d = (ovf_q & ~err_clr) | ovf_evt;
    udf_d = (udf_q & ~err_clr) | udf_evt;
    ord_d = (ord_q & ~err_clr) | ord_evt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      ord_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      ord_q <= ord_d;
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;
  assign order_err     = ord_q;
`else
  logic unused_err;
  assign unused_err    = ^{err_clr, ovf_evt, udf_evt, ord_evt};
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
  assign order_err     = 1'b0;
`endif

endmodule

// File: tb/tb_isr_nesting_stack.sv
// Directed bench for isr_nesting_stack: a DEPTH=8 instance for nesting/ordering/replace
// and a DEPTH=2 instance for overflow. Error expectations follow ISR_NEST_ERR_FLAGS_EN.
module tb_isr_nesting_stack;

`ifdef ISR_NEST_ERR_FLAGS_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // DEPTH=8 instance
  logic       reset_n = 1'b0, int_valid = 1'b0, cpu_ack = 1'b0, eoi = 1'b0, err_clr = 1'b0;
  logic [2:0] irq_id = '0;
  logic [2:0] prio;
  logic [7:0] active;
  logic [3:0] depth;
  logic       empty, full, ovf, udf, ord;
  wire [19:0] st = {prio, active, depth, empty, full, ovf, udf, ord};

  isr_nesting_stack #(.DEPTH(8), .ID_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .int_valid(int_valid), .irq_id(irq_id),
    .cpu_ack(cpu_ack), .eoi(eoi), .err_clr(err_clr),
    .current_isr_priority(prio), .isr_active(active), .nest_depth(depth),
    .stack_empty(empty), .stack_full(full),
    .overflow_err(ovf), .underflow_err(udf), .order_err(ord)
  );

  // DEPTH=2 instance
  logic       b_reset_n = 1'b0, b_int_valid = 1'b0, b_cpu_ack = 1'b0, b_eoi = 1'b0, b_err_clr = 1'b0;
  logic [2:0] b_irq_id = '0;
  logic [2:0] b_prio;
  logic [7:0] b_active;
  logic [1:0] b_depth;
  logic       b_empty, b_full, b_ovf, b_udf, b_ord;
  wire [17:0] b_st = {b_prio, b_active, b_depth, b_empty, b_full, b_ovf, b_udf, b_ord};

  isr_nesting_stack #(.DEPTH(2), .ID_W(3)) dut2 (
    .clk(clk), .reset_n(b_reset_n), .int_valid(b_int_valid), .irq_id(b_irq_id),
    .cpu_ack(b_cpu_ack), .eoi(b_eoi), .err_clr(b_err_clr),
    .current_isr_priority(b_prio), .isr_active(b_active), .nest_depth(b_depth),
    .stack_empty(b_empty), .stack_full(b_full),
    .overflow_err(b_ovf), .underflow_err(b_udf), .order_err(b_ord)
  );

  // Stimulus word: {cpu_ack, int_valid, irq_id, eoi, err_clr}
  localparam logic [6:0] EOI = 7'b00_000_10;
  localparam logic [6:0] CLR = 7'b00_000_01;
  function automatic logic [6:0] push(input logic [2:0] id);
    return {2'b11, id, 2'b00};
  endfunction

  // Expected word for DEPTH=8: {prio, active, depth, empty, full, ovf, udf, ord}
  function automatic logic [19:0] ex(input logic [2:0] p, input logic [7:0] a, input logic [3:0] d,
                                     input logic o, input logic u, input logic r);
    return {p, a, d, (d == 4'd0), (d == 4'd8), o, u, r};
  endfunction

  function automatic logic [17:0] ex2(input logic [2:0] p, input logic [7:0] a, input logic [1:0] d,
                                      input logic o, input logic u, input logic r);
    return {p, a, d, (d == 2'd0), (d == 2'd2), o, u, r};
  endfunction

  localparam logic [19:0] IDLE = {3'h7, 8'h00, 4'd0, 1'b1, 1'b0, 3'b000};

  task automatic test_reset();
    reset_n = 1'b0;
    {cpu_ack, int_valid, irq_id, eoi, err_clr} = push(3'd0) | EOI;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (st !== IDLE) $display("FAIL reset_held got %h want %h", st, IDLE);
    else passed++;
    {cpu_ack, int_valid, irq_id, eoi, err_clr} = '0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (st !== IDLE) $display("FAIL reset_release got %h want %h", st, IDLE);
    else passed++;
  endtask

  task automatic test_basic();
    logic [6:0]  stim [3];
    logic [19:0] exp  [3];
    stim = '{push(3'd0), EOI, 7'b10_010_00};
    exp  = '{ex(3'd0, 8'h01, 4'd1, 0, 0, 0), IDLE, IDLE};
    for (int i = 0; i < 3; i++) begin
      {cpu_ack, int_valid, irq_id, eoi, err_clr} = stim[i];
      @(posedge clk); #1;
      {cpu_ack, int_valid, irq_id, eoi, err_clr} = '0;
      total++;
      if (st !== exp[i]) $display("FAIL basic[%0d] got %h want %h", i, st, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_nesting();
    logic [6:0]  stim [4];
    logic [19:0] exp  [4];
    stim = '{push(3'd3), push(3'd1), EOI, EOI};
    exp  = '{ex(3'd3, 8'h08, 4'd1, 0, 0, 0), ex(3'd1, 8'h0A, 4'd2, 0, 0, 0),
             ex(3'd3, 8'h08, 4'd1, 0, 0, 0), IDLE};
    for (int i = 0; i < 4; i++) begin
      {cpu_ack, int_valid, irq_id, eoi, err_clr} = stim[i];
      @(posedge clk); #1;
      {cpu_ack, int_valid, irq_id, eoi, err_clr} = '0;
      total++;
      if (st !== exp[i]) $display("FAIL nesting[%0d] got %h want %h", i, st, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_order();
    logic [6:0]  stim [7];
    logic [19:0] exp  [7];
    stim = '{push(3'd3), push(3'd5), push(3'd3), CLR, push(3'd6) | CLR, CLR, EOI};
    exp  = '{ex(3'd3, 8'h08, 4'd1, 0, 0, 0), ex(3'd3, 8'h08, 4'd1, 0, 0, E),
             ex(3'd3, 8'h08, 4'd1, 0, 0, E), ex(3'd3, 8'h08, 4'd1, 0, 0, 0),
             ex(3'd3, 8'h08, 4'd1, 0, 0, E), ex(3'd3, 8'h08, 4'd1, 0, 0, 0), IDLE};
    for (int i = 0; i < 7; i++) begin
      {cpu_ack, int_valid, irq_id, eoi, err_clr} = stim[i];
      @(posedge clk); #1;
      {cpu_ack, int_valid, irq_id, eoi, err_clr} = '0;
      total++;
      if (st !== exp[i]) $display("FAIL order[%0d] got %h want %h", i, st, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_replace_underflow();
    logic [6:0]  stim [12];
    logic [19:0] exp  [12];
    stim = '{push(3'd3), push(3'd2) | EOI, EOI, EOI, CLR,
             push(3'd5) | EOI, push(3'd4) | CLR, push(3'd6) | EOI, EOI | CLR,
             push(3'd7), push(3'd7), EOI | CLR};
    exp  = '{ex(3'd3, 8'h08, 4'd1, 0, 0, 0), ex(3'd2, 8'h04, 4'd1, 0, 0, 0), IDLE,
             ex(3'd7, 8'h00, 4'd0, 0, E, 0), IDLE,
             ex(3'd5, 8'h20, 4'd1, 0, E, 0), ex(3'd4, 8'h30, 4'd2, 0, 0, 0),
             ex(3'd5, 8'h20, 4'd1, 0, 0, E), IDLE,
             ex(3'd7, 8'h80, 4'd1, 0, 0, 0), ex(3'd7, 8'h80, 4'd1, 0, 0, E), IDLE};
    for (int i = 0; i < 12; i++) begin
      {cpu_ack, int_valid, irq_id, eoi, err_clr} = stim[i];
      @(posedge clk); #1;
      {cpu_ack, int_valid, irq_id, eoi, err_clr} = '0;
      total++;
      if (st !== exp[i]) $display("FAIL replace[%0d] got %h want %h", i, st, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_full_and_reset();
    logic [6:0]  stim [10];
    logic [19:0] exp  [10];
    stim = '{push(3'd7), push(3'd6), push(3'd5), push(3'd4), push(3'd3),
             push(3'd2), push(3'd1), push(3'd0), EOI, push(3'd0)};
    exp  = '{ex(3'd7, 8'h80, 4'd1, 0, 0, 0), ex(3'd6, 8'hC0, 4'd2, 0, 0, 0),
             ex(3'd5, 8'hE0, 4'd3, 0, 0, 0), ex(3'd4, 8'hF0, 4'd4, 0, 0, 0),
             ex(3'd3, 8'hF8, 4'd5, 0, 0, 0), ex(3'd2, 8'hFC, 4'd6, 0, 0, 0),
             ex(3'd1, 8'hFE, 4'd7, 0, 0, 0), ex(3'd0, 8'hFF, 4'd8, 0, 0, 0),
             ex(3'd1, 8'hFE, 4'd7, 0, 0, 0), ex(3'd0, 8'hFF, 4'd8, 0, 0, 0)};
    for (int i = 0; i < 10; i++) begin
      {cpu_ack, int_valid, irq_id, eoi, err_clr} = stim[i];
      @(posedge clk); #1;
      {cpu_ack, int_valid, irq_id, eoi, err_clr} = '0;
      total++;
      if (st !== exp[i]) $display("FAIL full[%0d] got %h want %h", i, st, exp[i]);
      else passed++;
    end
    reset_n = 1'b0;
    eoi     = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    eoi     = 1'b0;
    total++;
    if (st !== IDLE) $display("FAIL mid_nest_reset got %h want %h", st, IDLE);
    else passed++;
  endtask

  task automatic test_overflow_depth2();
    logic [6:0]  stim [5];
    logic [17:0] exp  [5];
    logic        rst  [5];
    stim = '{push(3'd6), push(3'd4), push(3'd2), EOI, push(3'd1)};
    rst  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp  = '{ex2(3'd6, 8'h40, 2'd1, 0, 0, 0), ex2(3'd4, 8'h50, 2'd2, 0, 0, 0),
             ex2(3'd4, 8'h50, 2'd2, E, 0, 0), ex2(3'd6, 8'h40, 2'd1, E, 0, 0),
             ex2(3'd1, 8'h02, 2'd1, 0, 0, 0)};
    b_reset_n = 1'b0;
    @(posedge clk); #1;
    b_reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        b_reset_n = 1'b0;
        @(posedge clk); #1;
        b_reset_n = 1'b1;
        total++;
        if (b_st !== ex2(3'd7, 8'h00, 2'd0, 0, 0, 0))
          $display("FAIL d2_reset got %h want %h", b_st, ex2(3'd7, 8'h00, 2'd0, 0, 0, 0));
        else passed++;
      end
      b_reset_n = rst[i];
      {b_cpu_ack, b_int_valid, b_irq_id, b_eoi, b_err_clr} = stim[i];
      @(posedge clk); #1;
      {b_cpu_ack, b_int_valid, b_irq_id, b_eoi, b_err_clr} = '0;
      total++;
      if (b_st !== exp[i]) $display("FAIL d2_overflow[%0d] got %h want %h", i, b_st, exp[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nesting();
    test_order();
    test_replace_underflow();
    test_full_and_reset();
    test_overflow_depth2();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
